pc_seq: RTL
===========

# pc_seq

Parametrised program-counter sequencer for the datapath. It holds the current instruction address and advances it each enabled cycle. It also supports absolute jumps, signed relative branches, stall, and subroutine call/return through an internal return-address stack. It sits ahead of instruction memory and replaces the fixed 8-bit pass-through program counter with a registered, controllable one.

## Interface
- AW, 8, address width in bits (≥4)
- DEPTH, 4, return-stack entries (≥1, power of two not required)
- RESET_ADDR, 0, value loaded into pc on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance pc this cycle (pc+1 when no other command)
- stall  in  1  freeze pc and stack; overrides every other command
- load  in  1  absolute jump to addr_in
- branch  in  1  relative jump: pc + sign-extended offset
- call  in  1  push pc+1, then jump to addr_in
- ret  in  1  pop top of stack into pc
- addr_in  in  AW  jump/call target
- offset  in  AW  two's-complement branch displacement
- clr_err  in  1  synchronous clear of the sticky error flags
- pc  out  AW  current address (registered)
- depth  out  $clog2(DEPTH+1)  valid stack entries
- stk_full  out  1  depth == DEPTH
- stk_empty  out  1  depth == 0
- err_ovf  out  1  sticky: call attempted while full
- err_unf  out  1  sticky: ret attempted while empty

## Operation
- Reset (asynchronous, rst_n low):
  - pc = RESET_ADDR, depth = 0, stk_full = 0, stk_empty = 1, err_ovf = 0, err_unf = 0.
  - Stack contents are don't-care.
- One command executes per cycle, in fixed priority: stall > ret > call > load > branch > en > hold.
- Lower-priority commands asserted in the same cycle are ignored and have no side effects.
- stall: pc, stack and depth are unchanged; error flags are unchanged; clr_err still acts.
- ret:
  - Not empty: pc = stack top; depth-1.
  - Empty: pc holds; err_unf set.
- call:
  - Not full: stack[depth] = pc+1 (mod 2^AW); depth+1; pc = addr_in.
  - Full: no push; pc holds; err_ovf set.
- load: pc = addr_in.
- branch: pc = pc + offset, with offset sign-extended, result mod 2^AW. offset = 0 means pc holds.
- en: pc = pc+1 mod 2^AW. All-ones wraps to 0.
- No command asserted: pc holds.
- clr_err:
  - Clears both error flags.
  - If the same cycle sets a flag, the set wins.
- Stack is LIFO. Entries above depth are never read.
- All arithmetic is unsigned modulo 2^AW. No carry or overflow output.

## Timing
- All outputs are registered and change only on the rising clk edge, except on asynchronous reset assertion.
- Command-to-pc latency is 1 cycle: inputs sampled at edge N appear on pc after edge N.
- depth, stk_full, stk_empty and the error flags update on the same edge as pc.
- No handshake. Commands are level-sampled every cycle, so holding en high advances pc every cycle.
- Back-to-back call/ret is legal. A ret in the cycle after a call returns to the pushed pc+1.
- Reset deassertion is synchronised externally. The first command is sampled on the first edge after rst_n rises.
- Reset asserted mid-sequence discards the stack (depth = 0) immediately, without waiting for clk.

## Test plan
- Reset and increment:
  - Stimulus: assert rst_n low; release; hold en = 1 for 300 cycles with AW = 8.
  - Required: pc = 00 after reset; 01, 02, … each cycle; FF wraps to 00.
- Load and branch:
  - Stimulus: from pc = 10, load with addr_in = F0; next cycle branch with offset = FE; next cycle branch with offset = 20.
  - Required: pc = F0, then EE, then 0E (wrap).
- Call/return nesting:
  - Stimulus: from pc = 05, call addr_in = 40; call addr_in = 80; ret; ret.
  - Required:
    - pc = 40, depth 1; pc = 80, depth 2.
    - pc = 41, depth 1; pc = 06, depth 0.
    - stk_empty = 1 at the end.
- Overflow and underflow (DEPTH = 4):
  - Stimulus: five consecutive calls; then five rets; then clr_err.
  - Required:
    - 5th call: pc unchanged, err_ovf = 1, stk_full = 1.
    - 5th ret: pc unchanged, err_unf = 1.
    - After clr_err: both flags 0.
- Priority and stall:
  - Stimulus: assert stall + call + en together; then ret + load + en with depth 1.
  - Required:
    - Stall cycle: pc, depth and flags unchanged.
    - Next cycle: ret wins; pc = popped value; load is ignored.
- Asynchronous reset mid-operation:
  - Stimulus: with depth = 3 and pc = 80, pull rst_n low between clock edges.
  - Required: pc = RESET_ADDR and depth = 0 immediately, without a clk edge.

Source files
------------

// File: rtl/pc_seq_if.sv
// pc_seq_if: command and status bundle for the program-counter sequencer.
//   Commands (master -> slave): en, stall, load, branch, call, ret, addr_in, offset, clr_err
//   Status   (slave -> master): pc, depth, stk_full, stk_empty, err_ovf, err_unf
// AW and DEPTH must match the parameters of the pc_seq instance attached to it.
interface pc_seq_if #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic          en;
    logic          stall;
    logic          load;
    logic          branch;
    logic          call;
    logic          ret;
    logic [AW-1:0] addr_in;
    logic [AW-1:0] offset;
    logic          clr_err;

    logic [AW-1:0] pc;
    logic [DW-1:0] depth;
    logic          stk_full;
    logic          stk_empty;
    logic          err_ovf;
    logic          err_unf;

    modport master (
        output en, stall, load, branch, call, ret, addr_in, offset, clr_err,
        input  pc, depth, stk_full, stk_empty, err_ovf, err_unf
    );

    modport slave (
        input  en, stall, load, branch, call, ret, addr_in, offset, clr_err,
        output pc, depth, stk_full, stk_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_seq.sv
// pc_seq: registered program counter with increment, absolute jump, relative branch,
// stall and call/return through an internal LIFO return-address stack.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_seq_if slave modport carrying commands in and pc/stack/error status out
// One command per cycle, priority stall > ret > call > load > branch > en > hold.
// All outputs come straight from flops.
module pc_seq #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DEPTH      = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_seq_if.slave    bus
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    // Stack index width; a single-entry stack still needs a 1-bit index.
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FullCnt = DW'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          full_q, empty_q;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [AW-1:0] stk_q [DEPTH];

    logic          push;
    logic          ovf_set;
    logic          unf_set;
    logic [AW-1:0] pc_inc;
    logic [DW-1:0] top_cnt;

    assign pc_inc  = pc_q + AW'(1);
    assign top_cnt = depth_q - DW'(1);

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;

        if (bus.stall) begin
            // Freeze pc and stack; error flags still see clr_err below.
        end else if (bus.ret) begin
            if (depth_q != '0) begin
                pc_d    = stk_q[top_cnt[IW-1:0]];
                depth_d = top_cnt;
            end else begin
                unf_set = 1'b1;
            end
        end else if (bus.call) begin
            if (depth_q != FullCnt) begin
                push    = 1'b1;
                pc_d    = bus.addr_in;
                depth_d = depth_q + DW'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end else if (bus.load) begin
            pc_d = bus.addr_in;
        end else if (bus.branch) begin
            // Same-width add is the sign-extended add modulo 2^AW.
            pc_d = pc_q + bus.offset;
        end else if (bus.en) begin
            pc_d = pc_inc;
        end

        // A flag being set this cycle beats a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
        unf_d = unf_set | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            full_q  <= (depth_d == FullCnt);
            empty_q <= (depth_d == '0);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage carries no reset: entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            stk_q[depth_q[IW-1:0]] <= pc_inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.depth     = depth_q;
    assign bus.stk_full  = full_q;
    assign bus.stk_empty = empty_q;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_unf   = unf_q;
endmodule
